// File: rtl/tft_uart_report.sv
// tft_uart_report: transmit-side frame formatter for the TFT UART protocol.
// Builds "TFT_R:o,dddd\r\n" status reports and "TFT_D:lllll\r\n" dumps
// (binary words followed by DONE/FAIL) and feeds them to a byte serializer
// over a valid/ready handshake. All outputs are registered: each output is
// loaded from a function of the next state, so the byte for the next
// position is already on tx_data in the cycle after a transfer.
module tft_uart_report #(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rpt_req,
  input  logic [3:0]  rpt_opcode,
  input  logic [15:0] rpt_data,
  input  logic        dump_req,
  input  logic [19:0] dump_len,
  input  logic [15:0] dump_word,
  input  logic        dump_word_valid,
  output logic        dump_word_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HDR     = 4'd1,
    S_R_OP    = 4'd2,
    S_R_COMMA = 4'd3,
    S_R_DATA  = 4'd4,
    S_D_LEN   = 4'd5,
    S_CRLF    = 4'd6,
    S_D_FETCH = 4'd7,
    S_D_HI    = 4'd8,
    S_D_LO    = 4'd9,
    S_TAIL    = 4'd10
  } state_t;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h37 + {4'h0, n};
    end
    return c;
  endfunction

  // Byte that belongs on the wire for a given frame position.
  function automatic logic [7:0] frame_byte(
    input state_t      st,
    input logic [2:0]  ix,
    input logic        dmp,
    input logic        fl,
    input logic [3:0]  op,
    input logic [15:0] dat,
    input logic [19:0] len,
    input logic [15:0] wd
  );
    logic [7:0] b;
    b = 8'h00;
    case (st)
      S_HDR: begin
        case (ix)
          3'd0:    b = 8'h54;                 // T
          3'd1:    b = 8'h46;                 // F
          3'd2:    b = 8'h54;                 // T
          3'd3:    b = 8'h5F;                 // _
          3'd4:    b = dmp ? 8'h44 : 8'h52;   // D or R
          3'd5:    b = 8'h3A;                 // :
          default: b = 8'h00;
        endcase
      end
      S_R_OP:    b = hex_char(op);
      S_R_COMMA: b = 8'h2C;
      S_R_DATA: begin
        case (ix)
          3'd0:    b = hex_char(dat[15:12]);
          3'd1:    b = hex_char(dat[11:8]);
          3'd2:    b = hex_char(dat[7:4]);
          3'd3:    b = hex_char(dat[3:0]);
          default: b = 8'h00;
        endcase
      end
      S_D_LEN: begin
        case (ix)
          3'd0:    b = hex_char(len[19:16]);
          3'd1:    b = hex_char(len[15:12]);
          3'd2:    b = hex_char(len[11:8]);
          3'd3:    b = hex_char(len[7:4]);
          3'd4:    b = hex_char(len[3:0]);
          default: b = 8'h00;
        endcase
      end
      S_CRLF: b = (ix == 3'd0) ? 8'h0D : 8'h0A;
      S_D_HI: b = wd[15:8];
      S_D_LO: b = wd[7:0];
      S_TAIL: begin
        case (ix)
          3'd0:    b = fl ? 8'h46 : 8'h44;    // F / D
          3'd1:    b = fl ? 8'h41 : 8'h4F;    // A / O
          3'd2:    b = fl ? 8'h49 : 8'h4E;    // I / N
          3'd3:    b = fl ? 8'h4C : 8'h45;    // L / E
          3'd4:    b = 8'h0D;
          3'd5:    b = 8'h0A;
          default: b = 8'h00;
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t                 state, state_n;
  logic [2:0]             idx, idx_n;
  logic [3:0]             op_q, op_n;
  logic [15:0]            data_q, data_n;
  logic [19:0]            len_q, len_n;
  logic [19:0]            remain, remain_n;
  logic [15:0]            word_q, word_n;
  logic                   is_dump, dump_n;
  logic                   fail, fail_n;
  logic [TIMEOUT_W-1:0]   timer, timer_n;
  logic [7:0]             tx_data_n;
  logic                   tx_valid_n;
  logic                   ready_n;
  logic                   busy_n;
  logic                   done_n;
  logic                   err_n;
  logic                   xfer;

  assign xfer = tx_valid & tx_ready;

  // Next-state, frame bookkeeping and next registered outputs.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    op_n     = op_q;
    data_n   = data_q;
    len_n    = len_q;
    remain_n = remain;
    word_n   = word_q;
    dump_n   = is_dump;
    fail_n   = fail;
    timer_n  = {TIMEOUT_W{1'b0}};
    done_n   = 1'b0;
    err_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (rpt_req) begin
          state_n = S_HDR;
          idx_n   = 3'd0;
          dump_n  = 1'b0;
          fail_n  = 1'b0;
          op_n    = rpt_opcode;
          data_n  = rpt_data;
        end else if (dump_req) begin
          state_n  = S_HDR;
          idx_n    = 3'd0;
          dump_n   = 1'b1;
          fail_n   = 1'b0;
          len_n    = dump_len;
          remain_n = dump_len;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_HDR: begin
        if (xfer && (idx == 3'd5)) begin
          state_n = is_dump ? S_D_LEN : S_R_OP;
          idx_n   = 3'd0;
        end else if (xfer) begin
          idx_n = idx + 3'd1;
        end else begin
          idx_n = idx;
        end
      end
      S_R_OP: begin
        if (xfer) begin
          state_n = S_R_COMMA;
        end else begin
          state_n = S_R_OP;
        end
      end
      S_R_COMMA: begin
        if (xfer) begin
          state_n = S_R_DATA;
          idx_n   = 3'd0;
        end else begin
          state_n = S_R_COMMA;
        end
      end
      S_R_DATA: begin
        if (xfer && (idx == 3'd3)) begin
          state_n = S_CRLF;
          idx_n   = 3'd0;
        end else if (xfer) begin
          idx_n = idx + 3'd1;
        end else begin
          idx_n = idx;
        end
      end
      S_D_LEN: begin
        if (xfer && (idx == 3'd4)) begin
          state_n = S_CRLF;
          idx_n   = 3'd0;
        end else if (xfer) begin
          idx_n = idx + 3'd1;
        end else begin
          idx_n = idx;
        end
      end
      S_CRLF: begin
        if (xfer && (idx == 3'd1)) begin
          // Report frames end here; dumps move on to the payload.
          state_n = is_dump ? S_D_FETCH : S_IDLE;
          done_n  = ~is_dump;
          idx_n   = 3'd0;
        end else if (xfer) begin
          idx_n = idx + 3'd1;
        end else begin
          idx_n = idx;
        end
      end
      S_D_FETCH: begin
        // ready is high throughout this state, so valid alone means capture.
        if (dump_word_valid) begin
          word_n  = dump_word;
          state_n = S_D_HI;
        end else if (timer[TIMEOUT_W-1]) begin
          state_n = S_TAIL;
          fail_n  = 1'b1;
          idx_n   = 3'd0;
        end else begin
          timer_n = timer + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
      end
      S_D_HI: begin
        if (xfer) begin
          state_n = S_D_LO;
        end else begin
          state_n = S_D_HI;
        end
      end
      S_D_LO: begin
        // Exit test is on the count before decrement so it never wraps.
        if (xfer && (remain == 20'd0)) begin
          state_n = S_TAIL;
          fail_n  = 1'b0;
          idx_n   = 3'd0;
        end else if (xfer) begin
          remain_n = remain - 20'd1;
          state_n  = S_D_FETCH;
        end else begin
          state_n = S_D_LO;
        end
      end
      S_TAIL: begin
        if (xfer && (idx == 3'd5)) begin
          state_n = S_IDLE;
          done_n  = ~fail;
          err_n   = fail;
          idx_n   = 3'd0;
        end else if (xfer) begin
          idx_n = idx + 3'd1;
        end else begin
          idx_n = idx;
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = 3'd0;
      end
    endcase

    busy_n     = (state_n != S_IDLE);
    ready_n    = (state_n == S_D_FETCH);
    tx_valid_n = (state_n != S_IDLE) && (state_n != S_D_FETCH);
    if (tx_valid_n) begin
      tx_data_n = frame_byte(state_n, idx_n, dump_n, fail_n, op_n, data_n,
                             len_n, word_n);
    end else begin
      tx_data_n = 8'h00;
    end
  end

  // State, frame context and registered outputs; async clear truncates any frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= S_IDLE;
      idx             <= 3'd0;
      op_q            <= 4'h0;
      data_q          <= 16'h0000;
      len_q           <= 20'h00000;
      remain          <= 20'h00000;
      word_q          <= 16'h0000;
      is_dump         <= 1'b0;
      fail            <= 1'b0;
      timer           <= {TIMEOUT_W{1'b0}};
      tx_data         <= 8'h00;
      tx_valid        <= 1'b0;
      dump_word_ready <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      op_q            <= op_n;
      data_q          <= data_n;
      len_q           <= len_n;
      remain          <= remain_n;
      word_q          <= word_n;
      is_dump         <= dump_n;
      fail            <= fail_n;
      timer           <= timer_n;
      tx_data         <= tx_data_n;
      tx_valid        <= tx_valid_n;
      dump_word_ready <= ready_n;
      busy            <= busy_n;
      done            <= done_n;
      err             <= err_n;
    end
  end

endmodule

// File: tb/tb_tft_uart_report.sv
// Scoreboard bench for tft_uart_report: stimulus pushes expected bytes and
// completion events; a negedge monitor pops and compares on every transfer.
module tb_tft_uart_report;

  logic        clk;
  logic        nrst;
  logic        rpt_req;
  logic [3:0]  rpt_opcode;
  logic [15:0] rpt_data;
  logic        dump_req;
  logic [19:0] dump_len;
  logic [15:0] dump_word;
  logic        dump_word_valid;
  logic        dump_word_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        err;

  tft_uart_report #(.TIMEOUT_W(4)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .rpt_req         (rpt_req),
    .rpt_opcode      (rpt_opcode),
    .rpt_data        (rpt_data),
    .dump_req        (dump_req),
    .dump_len        (dump_len),
    .dump_word       (dump_word),
    .dump_word_valid (dump_word_valid),
    .dump_word_ready (dump_word_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  evt_q[$];
  logic [15:0] wq[$];
  int evt_cnt = 0;
  int last_evt_cyc = 0;
  int busy_cycles = 0;
  int rdy_rises = 0;
  logic bp_en = 1'b0;

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic wait_evt(input int maxc, input string nm);
    int s;
    int n;
    s = evt_cnt;
    n = 0;
    while (evt_cnt == s && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (evt_cnt == s) begin
      bad++;
      $display("FAIL %s: no done/err within %0d cycles", nm, maxc);
    end
  endtask

  // tx_ready driver: always ready, or pseudo-random under backpressure.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) tx_ready = 1'($urandom_range(0, 1));
      else       tx_ready = 1'b1;
    end
  end

  // Dump word source: presents the head of wq and pops it once taken.
  initial begin
    logic took;
    dump_word_valid = 1'b0;
    dump_word = 16'h0000;
    forever begin
      @(negedge clk);
      took = dump_word_valid && dump_word_ready && nrst;
      @(posedge clk); #1;
      if (took && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0) begin
        dump_word_valid = 1'b1;
        dump_word = wq[0];
      end else begin
        dump_word_valid = 1'b0;
      end
    end
  end

  // Monitor: byte scoreboard, hold-under-backpressure, completion events.
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_rdy;
    logic [7:0] e;
    logic [7:0] got;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    prev_rdy  = 1'b0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        prev_hold = 1'b0;
        prev_rdy  = 1'b0;
      end else begin
        if (prev_hold) begin
          total++;
          if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
            bad++;
            $display("FAIL hold: valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, prev_data);
          end
        end
        if (tx_valid && tx_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL byte: unexpected byte %h with empty scoreboard", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              bad++;
              $display("FAIL byte: got %h expected %h", tx_data, e);
            end
          end
        end
        if (done || err) begin
          got = (done && err) ? 8'h58 : (done ? 8'h44 : 8'h45);
          total++;
          if (evt_q.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected %s", (got == 8'h44) ? "done" : "err");
          end else begin
            e = evt_q.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL event: got %c expected %c", got, e);
            end
          end
          evt_cnt++;
          last_evt_cyc = cyc;
        end
        if (dump_word_ready && !prev_rdy) rdy_rises++;
        prev_rdy = dump_word_ready;
        if (busy) busy_cycles++;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int k;
    int saved;
    nrst = 1'b0;
    rpt_req = 1'b0;
    rpt_opcode = 4'h0;
    rpt_data = 16'h0000;
    dump_req = 1'b0;
    dump_len = 20'h00000;
    #1;
    chk("reset tx_data", 32'(tx_data), 32'h00);
    chk("reset tx_valid", 32'(tx_valid), 32'h0);
    chk("reset ready", 32'(dump_word_ready), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done_err", 32'({done, err}), 32'h0);
    repeat (3) @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk); #1;

    // Report with full throughput and latency checks.
    push_str("TFT_R:A,1F3C\r\n");
    evt_q.push_back(8'h44);
    rpt_opcode = 4'hA;
    rpt_data = 16'h1F3C;
    busy_cycles = 0;
    rpt_req = 1'b1;
    @(posedge clk); #1;
    rpt_req = 1'b0;
    k = cyc;
    chk("first byte valid", 32'(tx_valid), 32'h1);
    chk("first byte T", 32'(tx_data), 32'h54);
    chk("busy after accept", 32'(busy), 32'h1);
    wait_evt(60, "report");
    chk("done cycle", 32'(last_evt_cyc), 32'(k + 14));
    chk("busy cycles", 32'(busy_cycles), 32'd14);
    chk("report drained", 32'(exp_q.size()), 32'd0);

    // Dump of two words.
    wq.push_back(16'hBEEF);
    wq.push_back(16'h0102);
    push_str("TFT_D:00001\r\n");
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    push_str("DONE\r\n");
    evt_q.push_back(8'h44);
    rdy_rises = 0;
    dump_len = 20'h00001;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    wait_evt(200, "dump");
    chk("ready rises", 32'(rdy_rises), 32'd2);
    chk("dump drained", 32'(exp_q.size()), 32'd0);
    chk("words consumed", 32'(wq.size()), 32'd0);

    // Report under random backpressure.
    bp_en = 1'b1;
    push_str("TFT_R:A,1F3C\r\n");
    evt_q.push_back(8'h44);
    rpt_req = 1'b1;
    @(posedge clk); #1;
    rpt_req = 1'b0;
    wait_evt(400, "backpressure");
    bp_en = 1'b0;
    chk("bp drained", 32'(exp_q.size()), 32'd0);

    // Dump timeout after one word.
    wq.push_back(16'h1234);
    push_str("TFT_D:00002\r\n");
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    push_str("FAIL\r\n");
    evt_q.push_back(8'h45);
    dump_len = 20'h00002;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    wait_evt(300, "timeout");
    chk("timeout drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous requests, then a dump request while busy.
    push_str("TFT_R:5,00FF\r\n");
    evt_q.push_back(8'h44);
    rpt_opcode = 4'h5;
    rpt_data = 16'h00FF;
    dump_len = 20'h00003;
    rpt_req = 1'b1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    rpt_req = 1'b0;
    dump_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    wait_evt(60, "contention");
    saved = evt_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk("contention idle busy", 32'(busy), 32'h0);
    chk("contention idle valid", 32'(tx_valid), 32'h0);
    chk("contention drained", 32'(exp_q.size()), 32'd0);
    chk("contention no extra event", 32'(evt_cnt), 32'(saved));

    // Reset in the middle of the header.
    push_str("TFT_R:A,1F3C\r\n");
    evt_q.push_back(8'h44);
    rpt_opcode = 4'hA;
    rpt_data = 16'h1F3C;
    rpt_req = 1'b1;
    @(posedge clk); #1;
    rpt_req = 1'b0;
    repeat (3) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("mid reset tx_valid", 32'(tx_valid), 32'h0);
    chk("mid reset busy", 32'(busy), 32'h0);
    chk("mid reset tx_data", 32'(tx_data), 32'h00);
    exp_q.delete();
    evt_q.delete();
    saved = evt_cnt;
    @(negedge clk);
    @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk); #1;
    chk("no event after reset", 32'(evt_cnt), 32'(saved));
    push_str("TFT_R:A,1F3C\r\n");
    evt_q.push_back(8'h44);
    rpt_req = 1'b1;
    @(posedge clk); #1;
    rpt_req = 1'b0;
    chk("post reset first T", 32'(tx_data), 32'h54);
    wait_evt(60, "post reset report");
    chk("post reset drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tft_uart_report.md
# tft_uart_report

Transmit-side companion to the TFT UART command parser. It formats FPGA-to-host frames in the same ASCII protocol family: a status report `TFT_R:o,dddd\r\n` and a bulk readback dump `TFT_D:lllll\r\n`, followed by binary words and `DONE\r\n`. It sits between the display/SDRAM control logic and the shared `uart_tx` byte serializer, and drives a byte valid/ready handshake.

## Interface
- `TIMEOUT_W`, default 24: width of the dump word-wait timer. Timeout fires when bit `TIMEOUT_W-1` sets.
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `rpt_req`  in  1  single-cycle request to send a report frame.
- `rpt_opcode`  in  4  opcode, sent as 1 hex char.
- `rpt_data`  in  16  data, sent as 4 hex chars, MSB nibble first.
- `dump_req`  in  1  single-cycle request to start a dump frame.
- `dump_len`  in  20  word count minus 1; N = dump_len+1 words are sent.
- `dump_word`  in  16  dump payload word.
- `dump_word_valid`  in  1  `dump_word` is valid.
- `dump_word_ready`  out  1  block can accept a word.
- `tx_data`  out  8  byte to serializer.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  serializer accepts the byte.
- `busy`  out  1  high from request accept until `done`/`err`.
- `done`  out  1  one-cycle pulse when a frame completes normally.
- `err`  out  1  one-cycle pulse when a dump aborts on timeout.

## Operation
- Reset values: `tx_data`=0x00, `tx_valid`=0, `dump_word_ready`=0, `busy`=0, `done`=0, `err`=0, FSM=IDLE, timer=0.
- Requests are accepted only in IDLE. On accept, the block latches opcode/data/len internally and sets `busy`. Requests arriving while busy are ignored with no queueing. If `rpt_req` and `dump_req` arrive in the same IDLE cycle, the report wins and the dump is dropped.
- Hex encoding is uppercase: nibble n<10 → 0x30+n; n≥10 → 0x37+n.
- States:
  - IDLE
  - HDR: bytes `T`,`F`,`T`,`_`, then `R` or `D`, then `:`. A 3-bit index tracks position.
  - R_OP: 1 hex char.
  - R_COMMA: `,`.
  - R_DATA: 4 hex chars.
  - D_LEN: 5 hex chars of `dump_len`, bits [19:16] first.
  - CRLF: 0x0D, 0x0A.
  - D_FETCH
  - D_HI
  - D_LO
  - TAIL: `DONE\r\n` or `FAIL\r\n`, 6 bytes each.
- Report path: HDR → R_OP → R_COMMA → R_DATA → CRLF → IDLE with `done`. Total 14 bytes.
- Dump path: HDR → D_LEN → CRLF → D_FETCH → D_HI → D_LO.
  - After D_LO, return to D_FETCH while the remaining count > 0.
  - Otherwise go to TAIL(`DONE`) → IDLE with `done`.
  - The remaining count is a 20-bit down-counter loaded with `dump_len` and decremented after each D_LO transfer. No wrap is allowed: the exit test is count==0 before decrement.
- D_FETCH:
  - `dump_word_ready`=1. The word is captured on `valid&ready`, then `ready` drops.
  - The timer counts each cycle in D_FETCH without a capture and clears on capture.
  - On timeout: skip remaining words, go to TAIL(`FAIL`) → IDLE with `err` (no `done`).
- D_HI/D_LO send `word[15:8]` then `word[7:0]` as raw binary.

## Timing
- Byte handshake: a byte transfers on a cycle with `tx_valid`&&`tx_ready`.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold.
  - The next byte is presented the cycle after a transfer, so there is zero bubble within a frame except at D_FETCH.
- Latency: request accept at edge k. The first byte `T` is presented with `tx_valid`=1 from cycle k+1.
- D_FETCH:
  - `dump_word_ready` rises the cycle after the CRLF or D_LO transfer.
  - The high byte is presented the cycle after capture.
- `done`/`err` pulse in the cycle after the final 0x0A transfer. `busy` falls in that same cycle. A new request is accepted in that cycle at the earliest.
- `tx_valid`=0 in IDLE and D_FETCH.
- Reset mid-frame: all outputs return to reset values asynchronously and the frame is truncated. No `done`/`err` is emitted.

## Test plan
- Report: `rpt_req` with opcode=0xA, data=0x1F3C, `tx_ready`=1 → bytes `TFT_R:A,1F3C\r\n` (14 bytes), `done` at cycle k+15, `busy` high k+1..k+14.
- Dump: len=0x00001, words 0xBEEF, 0x0102 → `TFT_D:00001\r\n`, BE, EF, 01, 02, `DONE\r\n`. `dump_word_ready` is asserted twice.
- Backpressure: repeat the report with `tx_ready` toggling pseudo-randomly → identical byte sequence. `tx_data` is stable whenever `tx_valid`&&!`tx_ready`.
- Timeout: `TIMEOUT_W`=4, len=2, supply 1 word then none → header, 2 data bytes, `FAIL\r\n`, `err` pulse, no `done`.
- Contention: `rpt_req`+`dump_req` in the same cycle, then `dump_req` while busy → only the report frame is sent; `busy` drops and the block returns to IDLE.
- Reset: assert `nrst` low mid-header → `tx_valid`=0 immediately. After release, a new report transmits cleanly from `T`.
